cw305_crypt_sequencer: RTL
==========================

# cw305_crypt_sequencer

Sequences one block-cipher core (AES-class, load/busy handshake) in the crypto clock domain. Accepts a start pulse plus key/plaintext from the register block, issues the core load, tracks busy, captures the ciphertext, and reports ready/busy/done status. It also drives the capture trigger and a watchdog error. The block sits between the register block and the cipher core, replacing direct start/busy wiring.

## Interface
- pPT_WIDTH, 128, plaintext width
- pCT_WIDTH, 128, ciphertext width
- pKEY_WIDTH, 128, key width
- pTIMEOUT_WIDTH, 16, watchdog counter width
- pCNT_WIDTH, 8, repeat counter width
- crypto_clk  in  1  sole clock
- resetn  in  1  asynchronous, active-low reset
- I_start  in  1  single-cycle start pulse, crypto_clk domain
- I_key  in  pKEY_WIDTH  key, sampled on accepted start
- I_textin  in  pPT_WIDTH  plaintext, sampled on accepted start
- I_timeout  in  pTIMEOUT_WIDTH  watchdog limit in cycles; 0 disables
- I_repeat  in  pCNT_WIDTH  run count (CRYPT_SEQ_REPEAT_EN only)
- O_core_load  out  1  load pulse to core
- O_core_key  out  pKEY_WIDTH  registered key to core
- O_core_data  out  pPT_WIDTH  registered data to core
- I_core_busy  in  1  core busy
- I_core_data  in  pCT_WIDTH  core result
- O_cipherout  out  pCT_WIDTH  captured ciphertext
- O_ready / O_busy / O_done  out  1 each  status
- O_timeout_err  out  1  sticky watchdog error
- O_trigger  out  1  capture trigger
- O_run_cnt  out  pCNT_WIDTH  completed runs (CRYPT_SEQ_REPEAT_EN only)

## Operation
- States: IDLE, LOAD, ARM, RUN, CAPTURE.
- IDLE: on I_start, register I_key/I_textin into O_core_key/O_core_data, clear O_done and O_timeout_err, go to LOAD. I_start outside IDLE is ignored.
- LOAD: O_core_load=1 for exactly one cycle, then go to ARM.
- ARM: wait for I_core_busy=1, then go to RUN. If I_core_busy is already high in the ARM cycle, go to RUN immediately.
- RUN: wait for I_core_busy=0, then go to CAPTURE.
- CAPTURE: O_cipherout<=I_core_data. Then go to IDLE with O_done=1, or to LOAD for the next repeat.
- Watchdog: counter clears on entry to LOAD and increments each cycle in ARM/RUN. When it equals I_timeout (nonzero), set O_timeout_err=1, go to IDLE, leave O_done=0 and O_cipherout unchanged.
- O_ready=1 only in IDLE. O_busy=1 in any non-IDLE state.
- O_trigger is registered. It is high from the LOAD cycle through the last RUN cycle, and low in CAPTURE/IDLE.
- Reset, including reset mid-run: state IDLE; all outputs 0 except O_ready=1; data registers 0. The core is not reset by this block.

## Timing
- Start accepted at edge N: LOAD (load=1) at N+1, ARM at N+2.
- Core busy for B cycles starting at N+2: CAPTURE at N+3+B. O_done and O_cipherout are valid at N+4+B.
- Earliest next start is accepted in the first IDLE cycle.
- Counter widths: the watchdog compare is exact-equality and saturates; it never wraps.

## Configuration
- CRYPT_SEQ_REPEAT_EN defined:
  - I_repeat and O_run_cnt ports exist.
  - A run performs max(I_repeat,1) encryptions with chaining: after each CAPTURE, O_core_data<=I_core_data and the block returns to LOAD.
  - O_run_cnt clears on start and increments in each CAPTURE.
  - O_trigger stays high across the whole chain. A watchdog error aborts the chain.
- Not defined: the ports are absent and exactly one encryption runs per start.

## Structure
- Package cw305_crypt_pkg holds:
  - the state enum;
  - default widths;
  - the ready/busy/done encoding constants.
- Sub-module cw305_crypt_watchdog holds the clear/enable/limit counter with its error output.

## Test plan
- Core model with 10-cycle busy, start with pt=0x00112233…, key=0x0: load pulses once at N+1, O_done at N+14, O_cipherout equals the model output.
- Core busy never asserts, I_timeout=20: O_timeout_err=1 and IDLE after 20 ARM cycles, O_done=0.
- I_timeout=0 with 5000-cycle busy: no error, normal completion.
- Second start during RUN: ignored, exactly one load observed.
- resetn low mid-RUN: O_busy/O_trigger/O_core_load are 0 immediately, O_ready=1. A fresh start then completes normally.
- CRYPT_SEQ_REPEAT_EN, I_repeat=3:
  - three loads occur;
  - the data for each load equals the prior ciphertext;
  - O_run_cnt=3 at the end;
  - O_trigger is continuous across all three runs.

Source files
------------

// File: rtl/cw305_crypt_sequencer_pkg.sv
// Shared types and defaults for the CW305 crypt sequencer: FSM state enum,
// default datapath widths and {ready, busy, done} status encodings.
package cw305_crypt_pkg;

  localparam int unsigned DEF_PT_WIDTH      = 128;
  localparam int unsigned DEF_CT_WIDTH      = 128;
  localparam int unsigned DEF_KEY_WIDTH     = 128;
  localparam int unsigned DEF_TIMEOUT_WIDTH = 16;
  localparam int unsigned DEF_CNT_WIDTH     = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ARM,
    ST_RUN,
    ST_CAPTURE
  } crypt_state_t;

  // Status vectors are ordered {ready, busy, done}.
  localparam logic [2:0] STATUS_IDLE   = 3'b100;
  localparam logic [2:0] STATUS_ACTIVE = 3'b010;
  localparam logic [2:0] STATUS_DONE   = 3'b101;

endpackage

// File: rtl/cw305_crypt_sequencer_if.sv
// Load/busy handshake between the crypt sequencer (master) and a
// block-cipher core (slave).
interface cw305_crypt_sequencer_if
  import cw305_crypt_pkg::*;
#(
  parameter int unsigned pPT_WIDTH  = DEF_PT_WIDTH,
  parameter int unsigned pCT_WIDTH  = DEF_CT_WIDTH,
  parameter int unsigned pKEY_WIDTH = DEF_KEY_WIDTH
);
  logic                  O_core_load;
  logic [pKEY_WIDTH-1:0] O_core_key;
  logic [pPT_WIDTH-1:0]  O_core_data;
  logic                  I_core_busy;
  logic [pCT_WIDTH-1:0]  I_core_data;

  modport master (
    output O_core_load, O_core_key, O_core_data,
    input  I_core_busy, I_core_data
  );

  modport slave (
    input  O_core_load, O_core_key, O_core_data,
    output I_core_busy, I_core_data
  );
endinterface

// File: rtl/cw305_crypt_sequencer_watchdog.sv
// Cycle watchdog for the cipher handshake: clears on clr, counts while en,
// and flags err in the cycle the count reaches a nonzero limit.
module cw305_crypt_watchdog
  import cw305_crypt_pkg::*;
#(
  parameter int unsigned pTIMEOUT_WIDTH = DEF_TIMEOUT_WIDTH
) (
  input  logic                      crypto_clk,
  input  logic                      resetn,
  input  logic                      clr,
  input  logic                      en,
  input  logic [pTIMEOUT_WIDTH-1:0] limit,
  output logic                      err
);
  logic [pTIMEOUT_WIDTH-1:0] cnt;
  logic [pTIMEOUT_WIDTH-1:0] cnt_inc;

  // Saturate instead of wrapping so an exact-equality limit is never skipped.
  always_comb begin
    cnt_inc = cnt;
    if (cnt != '1) cnt_inc = cnt + pTIMEOUT_WIDTH'(1);
  end

  assign err = en && (limit != '0) && (cnt_inc == limit);

  always_ff @(posedge crypto_clk or negedge resetn) begin
    if (!resetn)  cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt_inc;
  end
endmodule

// File: rtl/cw305_crypt_sequencer.sv
// Start/load/busy/capture sequencer for one block-cipher core with status,
// capture trigger and watchdog. Define CRYPT_SEQ_REPEAT_EN for chained repeat runs.
module cw305_crypt_sequencer
  import cw305_crypt_pkg::*;
#(
  parameter int unsigned pPT_WIDTH      = DEF_PT_WIDTH,
  parameter int unsigned pCT_WIDTH      = DEF_CT_WIDTH,
  parameter int unsigned pKEY_WIDTH     = DEF_KEY_WIDTH,
  parameter int unsigned pTIMEOUT_WIDTH = DEF_TIMEOUT_WIDTH
`ifdef CRYPT_SEQ_REPEAT_EN
  ,
  parameter int unsigned pCNT_WIDTH     = DEF_CNT_WIDTH
`endif
) (
  input  logic                      crypto_clk,
  input  logic                      resetn,
  input  logic                      I_start,
  input  logic [pKEY_WIDTH-1:0]     I_key,
  input  logic [pPT_WIDTH-1:0]      I_textin,
  input  logic [pTIMEOUT_WIDTH-1:0] I_timeout,
`ifdef CRYPT_SEQ_REPEAT_EN
  input  logic [pCNT_WIDTH-1:0]     I_repeat,
  output logic [pCNT_WIDTH-1:0]     O_run_cnt,
`endif
  cw305_crypt_sequencer_if.master   core_if,
  output logic [pCT_WIDTH-1:0]      O_cipherout,
  output logic                      O_ready,
  output logic                      O_busy,
  output logic                      O_done,
  output logic                      O_timeout_err,
  output logic                      O_trigger
);
  crypt_state_t state;
  logic [2:0]   status;
  logic         wd_clr;
  logic         wd_en;
  logic         wd_err;
  logic         last_run;

  assign {O_ready, O_busy, O_done} = status;
  assign wd_clr = (state == ST_LOAD);
  assign wd_en  = (state == ST_ARM) || (state == ST_RUN);

  cw305_crypt_watchdog #(
    .pTIMEOUT_WIDTH(pTIMEOUT_WIDTH)
  ) u_watchdog (
    .crypto_clk(crypto_clk),
    .resetn    (resetn),
    .clr       (wd_clr),
    .en        (wd_en),
    .limit     (I_timeout),
    .err       (wd_err)
  );

`ifdef CRYPT_SEQ_REPEAT_EN
  logic [pCNT_WIDTH-1:0] run_tgt;
  logic [pCNT_WIDTH:0]   runs_after;

  assign runs_after = {1'b0, O_run_cnt} + (pCNT_WIDTH+1)'(1);
  assign last_run   = (runs_after >= {1'b0, run_tgt});
`else
  assign last_run = 1'b1;
`endif

  always_ff @(posedge crypto_clk or negedge resetn) begin
    if (!resetn) begin
      state               <= ST_IDLE;
      status              <= STATUS_IDLE;
      core_if.O_core_load <= 1'b0;
      core_if.O_core_key  <= '0;
      core_if.O_core_data <= '0;
      O_cipherout         <= '0;
      O_timeout_err       <= 1'b0;
      O_trigger           <= 1'b0;
`ifdef CRYPT_SEQ_REPEAT_EN
      O_run_cnt           <= '0;
      run_tgt             <= '0;
`endif
    end else begin
      core_if.O_core_load <= 1'b0;
      if (wd_err) begin
        state         <= ST_IDLE;
        status        <= STATUS_IDLE;
        O_timeout_err <= 1'b1;
        O_trigger     <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (I_start) begin
              core_if.O_core_key  <= I_key;
              core_if.O_core_data <= I_textin;
              core_if.O_core_load <= 1'b1;
              status              <= STATUS_ACTIVE;
              O_timeout_err       <= 1'b0;
              O_trigger           <= 1'b1;
              state               <= ST_LOAD;
`ifdef CRYPT_SEQ_REPEAT_EN
              O_run_cnt           <= '0;
              run_tgt             <= (I_repeat == '0) ? pCNT_WIDTH'(1) : I_repeat;
`endif
            end
          end
          ST_LOAD: state <= ST_ARM;
          ST_ARM: begin
            if (core_if.I_core_busy) state <= ST_RUN;
          end
          ST_RUN: begin
            // Trigger drops only at the end of the final run so a chain stays one window.
            if (!core_if.I_core_busy) begin
              state <= ST_CAPTURE;
              if (last_run) O_trigger <= 1'b0;
            end
          end
          ST_CAPTURE: begin
            O_cipherout <= core_if.I_core_data;
`ifdef CRYPT_SEQ_REPEAT_EN
            O_run_cnt   <= runs_after[pCNT_WIDTH-1:0];
`endif
            if (last_run) begin
              status <= STATUS_DONE;
              state  <= ST_IDLE;
            end else begin
              core_if.O_core_data <= pPT_WIDTH'(core_if.I_core_data);
              core_if.O_core_load <= 1'b1;
              state               <= ST_LOAD;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule
